// File: rtl/l1_trigger_collector.sv
// Merges rising edges of unmasked L1 beam triggers into timestamped words, queued in a FWFT FIFO.
// Optional L1_COLLECTOR_SOFT_TRIG_EN adds soft_trig_i and an MSB "soft-started" flag bit.
module l1_trigger_collector #(
  parameter int NBEAMS    = 48,
  parameter int TS_BITS   = 16,
  parameter int MERGE_LEN = 4,
  parameter int DEPTH     = 16
) (
  input  logic                      ifclk,
  input  logic                      ifclk_rst_i,
  input  logic [NBEAMS-1:0]         trig_i,
  input  logic [NBEAMS-1:0]         mask_i,
  input  logic [7:0]                holdoff_i,
  input  logic                      ts_rst_i,
`ifdef L1_COLLECTOR_SOFT_TRIG_EN
  input  logic                      soft_trig_i,
  output logic [TS_BITS+NBEAMS:0]   trig_dat_o,
`else
  output logic [TS_BITS+NBEAMS-1:0] trig_dat_o,
`endif
  output logic                      trig_valid_o,
  input  logic                      trig_ready_i,
  output logic [15:0]               drop_cnt_o,
  output logic                      busy_o
);

`ifdef L1_COLLECTOR_SOFT_TRIG_EN
  localparam int DW = TS_BITS + NBEAMS + 1;
`else
  localparam int DW = TS_BITS + NBEAMS;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int MW = (MERGE_LEN > 1) ? $clog2(MERGE_LEN) : 1;

  typedef enum logic [1:0] {IDLE, MERGE, PUSH, HOLDOFF} state_t;

  state_t              state_q, state_d;
  logic [TS_BITS-1:0]  ts_q, ts_d, cap_ts_q, cap_ts_d;
  logic [NBEAMS-1:0]   trig_dly_q, bitmap_q, bitmap_d, rise;
  logic [MW-1:0]       mcnt_q, mcnt_d;
  logic [7:0]          hcnt_q, hcnt_d;
  logic                flag_q, flag_d, soft_w, cap, cap_soft;
  logic [15:0]         drop_q, drop_d;
  logic [DW-1:0]       mem_q [DEPTH];
  logic [DW-1:0]       last_q, last_d, wr_word;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                wr_en, push, pop;

`ifdef L1_COLLECTOR_SOFT_TRIG_EN
  assign soft_w  = soft_trig_i;
  assign wr_word = {flag_q, cap_ts_q, bitmap_q};
`else
  assign soft_w  = 1'b0;
  assign wr_word = {cap_ts_q, bitmap_q};
`endif

  assign rise = trig_i & ~trig_dly_q & ~mask_i;
  assign ts_d = ts_rst_i ? '0 : ts_q + TS_BITS'(1);

  always_comb begin
    state_d  = state_q;
    cap_ts_d = cap_ts_q;
    bitmap_d = bitmap_q;
    mcnt_d   = mcnt_q;
    hcnt_d   = hcnt_q;
    flag_d   = flag_q;
    wr_en    = 1'b0;
    cap      = 1'b0;
    cap_soft = 1'b0;
    case (state_q)
      IDLE: begin
        cap      = (|rise) | soft_w;
        cap_soft = soft_w;
      end
      MERGE: begin
        bitmap_d = bitmap_q | rise;
        mcnt_d   = mcnt_q - MW'(1);
        if (mcnt_q <= MW'(1)) state_d = PUSH;
      end
      PUSH: begin
        wr_en = 1'b1;
        // With no holdoff the collector is immediately re-armed, so an edge in this cycle opens the next word.
        if (holdoff_i == 8'd0) begin
          state_d = IDLE;
          cap     = |rise;
        end else begin
          hcnt_d  = holdoff_i;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        hcnt_d = hcnt_q - 8'd1;
        if (hcnt_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      cap_ts_d = ts_q;
      bitmap_d = rise;
      flag_d   = cap_soft;
      mcnt_d   = MW'(MERGE_LEN - 1);
      state_d  = (MERGE_LEN == 1) ? PUSH : MERGE;
    end
  end

  always_comb begin
    pop      = (cnt_q != '0) & trig_ready_i;
    push     = wr_en & ((cnt_q != (AW+1)'(DEPTH)) | pop);
    cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    last_d   = pop  ? mem_q[rd_ptr_q] : last_q;
    drop_d   = drop_q;
    if (wr_en && !push && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge ifclk) begin
    if (ifclk_rst_i) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      trig_dly_q <= '0;
      cap_ts_q   <= '0;
      bitmap_q   <= '0;
      mcnt_q     <= '0;
      hcnt_q     <= '0;
      flag_q     <= 1'b0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      trig_dly_q <= trig_i;
      cap_ts_q   <= cap_ts_d;
      bitmap_q   <= bitmap_d;
      mcnt_q     <= mcnt_d;
      hcnt_q     <= hcnt_d;
      flag_q     <= flag_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge ifclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_word;
  end

  assign trig_valid_o = (cnt_q != '0);
  assign trig_dat_o   = trig_valid_o ? mem_q[rd_ptr_q] : last_q;
  assign drop_cnt_o   = drop_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_l1_trigger_collector.sv
// Scoreboard bench for l1_trigger_collector: directed triggers push expected words, a monitor pops on handshake.
module tb_l1_trigger_collector;
  localparam int NB = 48;
  localparam int TB = 16;
`ifdef L1_COLLECTOR_SOFT_TRIG_EN
  localparam int W = TB + NB + 1;
`else
  localparam int W = TB + NB;
`endif

  typedef struct {
    logic [W-1:0] dat;
    int           t;
  } exp_t;

  logic          clk = 1'b0, rst = 1'b1, ts_rst = 1'b0, ready = 1'b1;
  logic [NB-1:0] trig = '0, mask = '0;
  logic [7:0]    holdoff = 8'd0;
  logic [W-1:0]  dat;
  logic          valid, busy;
  logic [15:0]   drop;

  int   n_cmp = 0, n_err = 0;
  int   tb_ts = 0;
  exp_t q[$];
  logic stall_prev = 1'b0;
  logic [W-1:0] prev_dat;

  l1_trigger_collector dut (
    .ifclk(clk), .ifclk_rst_i(rst), .trig_i(trig), .mask_i(mask),
    .holdoff_i(holdoff), .ts_rst_i(ts_rst),
`ifdef L1_COLLECTOR_SOFT_TRIG_EN
    .soft_trig_i(1'b0),
`endif
    .trig_dat_o(dat), .trig_valid_o(valid), .trig_ready_i(ready),
    .drop_cnt_o(drop), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Reference timestamp: free-running, cleared by reset or ts_rst.
  always @(posedge clk) tb_ts <= (rst || ts_rst) ? 0 : tb_ts + 1;

  function automatic logic [W-1:0] mk(input int ts, input logic [NB-1:0] bm);
    logic [TB-1:0] t16;
    t16 = TB'(ts);
    return W'({t16, bm});
  endfunction

  function automatic logic [NB-1:0] b(input int i);
    logic [NB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic expect_word(input int ts, input logic [NB-1:0] bm, input int t);
    exp_t e;
    e.dat = mk(ts, bm);
    e.t   = t;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_ts(input int t);
    int n;
    n = 0;
    while (tb_ts != t && n < 3000) begin step(); n++; end
    if (tb_ts != t) begin
      n_cmp++; n_err++;
      $display("FAIL at_ts timeout: got ts %0d, expected %0d", tb_ts, t);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin step(); n++; end
    chk("drain", 128'(q.size()), 128'd0);
  endtask

  // Monitor: pop on handshake, check data and arrival time, and hold-stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_stable", 128'(dat), 128'(prev_dat));
      if (valid && ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got %0h, expected no word", dat);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word", 128'(dat), 128'(e.dat));
          if (e.t >= 0) chk("word_time", 128'(tb_ts), 128'(e.t));
        end
      end
      stall_prev = valid && !ready;
      prev_dat   = dat;
    end
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_valid", 128'(valid), 128'd0);
    chk("rst_dat",   128'(dat),   128'd0);
    chk("rst_drop",  128'(drop),  128'd0);
    chk("rst_busy",  128'(busy),  128'd0);

    // Single edge, latency and timestamp.
    at_ts(100); trig = b(3); expect_word(100, b(3), 105);
    at_ts(101); chk("busy_merge", 128'(busy), 128'd1);
    at_ts(102); trig = '0;

    // Merge window: beams 3 and 7 merged; beam 9 in the push cycle opens a new word.
    at_ts(200); trig = b(3); expect_word(200, b(3) | b(7), 205);
    at_ts(202); trig = b(7);
    at_ts(204); trig = b(9); expect_word(204, b(9), 209);
    at_ts(206); trig = '0;

    // Masking.
    mask = b(3);
    at_ts(300); trig = b(3);
    at_ts(301); chk("mask_busy0", 128'(busy), 128'd0);
    at_ts(302); chk("mask_busy1", 128'(busy), 128'd0); trig = '0;
    at_ts(310); trig = b(3) | b(5); expect_word(310, b(5), 315);
    at_ts(312); trig = '0;
    at_ts(320); mask = '0;

    // Holdoff: push at 404, holdoff 405..414.
    holdoff = 8'd10;
    at_ts(400); trig = b(1); expect_word(400, b(1), 405);
    at_ts(402); trig = '0;
    at_ts(406); trig = b(2);
    at_ts(408); trig = '0;
    at_ts(410); chk("busy_holdoff", 128'(busy), 128'd1);
    at_ts(416); trig = b(4); expect_word(416, b(4), 421);
    at_ts(418); trig = '0;
    at_ts(440); holdoff = 8'd0; chk("idle_after_holdoff", 128'(busy), 128'd0);

    // Overflow: 20 words while stalled, 16 kept, 4 dropped.
    at_ts(500); ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      at_ts(502 + 8 * k); trig = b(10 + k);
      if (k < 16) expect_word(502 + 8 * k, b(10 + k), -1);
      at_ts(504 + 8 * k); trig = '0;
    end
    at_ts(670);
    chk("drop_cnt", 128'(drop), 128'd4);
    chk("full_valid", 128'(valid), 128'd1);
    at_ts(680); ready = 1'b1;
    wait_empty();

    // Reset mid-merge with three words queued.
    at_ts(720); ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_ts(722 + 8 * k); trig = b(40 + k);
      at_ts(724 + 8 * k); trig = '0;
    end
    at_ts(750); trig = b(43);
    at_ts(752); trig = '0; rst = 1'b1;
    step(); step();
    rst = 1'b0; ready = 1'b1;
    step();
    chk("rst2_valid", 128'(valid), 128'd0);
    chk("rst2_drop",  128'(drop),  128'd0);
    chk("rst2_busy",  128'(busy),  128'd0);
    at_ts(3); trig = b(0); expect_word(3, b(0), 8);
    at_ts(5); trig = '0;
    wait_empty();

    // Timestamp clear.
    at_ts(30); ts_rst = 1'b1;
    step(); ts_rst = 1'b0;
    at_ts(5); trig = b(47); expect_word(5, b(47), 10);
    at_ts(7); trig = '0;
    wait_empty();
    repeat (20) step();
    chk("final_queue", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
